// File: rtl/grid_seq.sv
// grid_seq: sequencer for one grid lane. Walks N_IN operand pairs from the
// operand store, presents each pair to the grid with a one-cycle trig pulse,
// holds it for CONV_CYCLES, then captures the neuron output as the result.
module grid_seq #(
  parameter int N_IN        = 8,
  parameter int ADDR_W      = 3,
  parameter int CONV_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        bias_cfg,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_x,
  input  logic [7:0]        mem_w,
  input  logic              mem_wsign,
  output logic [7:0]        grid_din,
  output logic              grid_sign,
  output logic [7:0]        grid_win,
  output logic [7:0]        grid_bias,
  output logic              grid_trig,
  input  logic [7:0]        grid_dout,
  output logic [7:0]        result,
  output logic              result_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_TRIG,
    S_WAIT,
    S_NEXT,
    S_CAPTURE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          din_q, win_q, bias_q, result_q;
  logic                sign_q;
  logic                ld_bias, ld_op, ld_res;

  // Control state: FSM state, operand index and conversion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and strobes; abort overrides every non-IDLE transition
  // and also masks the strobes of the cycle it arrives in.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    ld_bias      = 1'b0;
    ld_op        = 1'b0;
    ld_res       = 1'b0;
    mem_rd_en    = 1'b0;
    grid_trig    = 1'b0;
    done         = 1'b0;
    result_valid = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            ld_bias = 1'b1;
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          mem_rd_en = 1'b1;
          state_d   = S_LOAD;
        end
        S_LOAD: begin
          ld_op   = 1'b1;
          state_d = S_TRIG;
        end
        S_TRIG: begin
          grid_trig = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (idx_q == ADDR_W'(N_IN - 1)) begin
            state_d = S_CAPTURE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
        S_CAPTURE: begin
          ld_res       = 1'b1;
          done         = 1'b1;
          result_valid = 1'b1;
          state_d      = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Datapath registers: operands, bias and captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q    <= '0;
      win_q    <= '0;
      sign_q   <= 1'b0;
      bias_q   <= '0;
      result_q <= '0;
    end else begin
      if (ld_bias) begin
        bias_q <= bias_cfg;
      end
      if (ld_op) begin
        din_q  <= mem_x;
        win_q  <= mem_w;
        sign_q <= mem_wsign;
      end
      if (ld_res) begin
        result_q <= grid_dout;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = idx_q;
  assign grid_din  = din_q;
  assign grid_win  = win_q;
  assign grid_sign = sign_q;
  assign grid_bias = bias_q;
  assign result    = result_q;

endmodule
